// File: rtl/fib_pkg.sv
// Shared Fibonacci constants and FSM state encoding.
// Used by the generator, the index decoder and their benches.
package fib_pkg;

  localparam int WIDTH = 13;
  localparam int IDX_W = 5;

  // Largest index and term that fit in WIDTH=13 bits
  localparam int FIB_MAX_IDX = 20;
  localparam int FIB_MAX     = 6765;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_index.sv
// Fibonacci index decoder: walks the sequence one add per clock
// until it meets or passes the captured value.
import fib_pkg::*;

module fib_index #(
  parameter int WIDTH = fib_pkg::WIDTH,
  parameter int IDX_W = fib_pkg::IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             ready,
  output logic [IDX_W-1:0] index,
  output logic             is_fib
);

  fib_state_e       r_state, w_state;
  logic [WIDTH-1:0] r_tgt, w_tgt;
  logic [WIDTH-1:0] r_prev, w_prev;
  logic [WIDTH-1:0] r_cur, w_cur;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [IDX_W-1:0] r_index, w_index;
  logic             r_is_fib, w_is_fib;
  logic [WIDTH:0]   w_sum;

  // One extra bit exposes the overflow of the next term
  assign w_sum = {1'b0, r_cur} + {1'b0, r_prev};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tgt    <= '0;
      r_prev   <= '0;
      r_cur    <= WIDTH'(1);
      r_idx    <= IDX_W'(1);
      r_index  <= '0;
      r_is_fib <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_tgt    <= w_tgt;
      r_prev   <= w_prev;
      r_cur    <= w_cur;
      r_idx    <= w_idx;
      r_index  <= w_index;
      r_is_fib <= w_is_fib;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_tgt    = r_tgt;
    w_prev   = r_prev;
    w_cur    = r_cur;
    w_idx    = r_idx;
    w_index  = r_index;
    w_is_fib = r_is_fib;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_tgt  = value;
          w_prev = '0;
          w_cur  = WIDTH'(1);
          w_idx  = IDX_W'(1);
          if (value == '0) begin
            w_state  = DONE;
            w_index  = '0;
            w_is_fib = 1'b1;
          end else begin
            w_state = RUN;
          end
        end
      end
      RUN: begin
        if (r_cur == r_tgt) begin
          w_state  = DONE;
          w_index  = r_idx;
          w_is_fib = 1'b1;
        end else if (r_cur > r_tgt) begin
          w_state  = DONE;
          w_index  = r_idx - IDX_W'(1);
          w_is_fib = 1'b0;
        end else if (w_sum[WIDTH]) begin
          w_state  = DONE;
          w_index  = r_idx;
          w_is_fib = 1'b0;
        end else begin
          w_prev = r_cur;
          w_cur  = w_sum[WIDTH-1:0];
          w_idx  = r_idx + IDX_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign busy   = (r_state == RUN);
  assign ready  = (r_state == DONE);
  assign index  = r_index;
  assign is_fib = r_is_fib;

endmodule

// File: tb/tb_fib_index.sv
// Randomised scoreboard bench for fib_index against a
// table-lookup model of the Fibonacci sequence.
module tb_fib_index;
  import fib_pkg::*;

  localparam int W   = fib_pkg::WIDTH;
  localparam int IW  = fib_pkg::IDX_W;
  localparam int TOP = (1 << W) - 1;

  typedef struct {
    int v;
    int idx;
    int fib;
    int lat;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  value = '0;
  logic          busy;
  logic          ready;
  logic [IW-1:0] index;
  logic          is_fib;

  int   checks = 0;
  int   errs   = 0;
  exp_t q[$];
  int   fib[0:30];
  logic acc  = 1'b0;
  logic pend = 1'b0;
  int   cnt  = 0;

  fib_index dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .ready (ready),
    .index (index),
    .is_fib(is_fib)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Model: index of v in the sequence, or of the largest
  // term below it; latency is the number of terms visited.
  function automatic exp_t model(int v);
    exp_t e;
    e.v   = v;
    e.idx = 0;
    e.fib = 0;
    e.lat = 0;
    if (v == 0) begin
      e.fib = 1;
      return e;
    end
    for (int k = 1; k <= 25; k++) begin
      if (fib[k] == v) begin
        e.idx = k;
        e.fib = 1;
        e.lat = k;
        return e;
      end
    end
    for (int k = 1; k <= 25; k++)
      if (fib[k] < v) e.idx = k;
    e.lat = (fib[e.idx + 1] > TOP) ? e.idx : e.idx + 1;
    return e;
  endfunction

  always @(posedge clock)
    acc <= start && !busy && !reset;

  always @(negedge clock) begin
    exp_t e;
    if (acc) begin
      pend = 1'b1;
      cnt  = 0;
    end
    if (busy) cnt++;
    chk("busy_ready_overlap", int'(busy && ready), 0);
    if (ready && pend) begin
      pend = 1'b0;
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("index(v=%0d)", e.v), int'(index), e.idx);
        chk($sformatf("is_fib(v=%0d)", e.v), int'(is_fib), e.fib);
        chk($sformatf("busy_cycles(v=%0d)", e.v), cnt, e.lat);
      end
    end
  end

  task automatic run_one(int v, bit noise);
    bit done;
    done  = 1'b0;
    start = 1'b1;
    value = W'(v);
    q.push_back(model(v));
    @(negedge clock);
    start = 1'b0;
    if (v != 0)
      chk($sformatf("ready_cleared(v=%0d)", v), int'(ready), 0);
    for (int c = 0; c < 40; c++) begin
      if (ready) begin
        done = 1'b1;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        value = W'($urandom);
      end
      @(negedge clock);
      start = 1'b0;
    end
    start = 1'b0;
    if (!done) chk($sformatf("timeout(v=%0d)", v), 0, 1);
    @(negedge clock);
  endtask

  function automatic int rand_val();
    int k;
    unique case ($urandom_range(0, 3))
      0: return fib[$urandom_range(1, 20)];
      1: begin
        k = fib[$urandom_range(3, 20)];
        return ($urandom_range(0, 1) != 0) ? k + 1 : k - 1;
      end
      2: return int'($urandom_range(0, TOP));
      default: return int'($urandom_range(6700, TOP));
    endcase
  endfunction

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int k = 2; k <= 30; k++) fib[k] = fib[k-1] + fib[k-2];

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_is_fib", int'(is_fib), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_one(0, 1'b0);
    run_one(8, 1'b0);
    run_one(10, 1'b0);
    run_one(6765, 1'b0);
    run_one(8191, 1'b0);
    run_one(1, 1'b0);
    run_one(2, 1'b0);

    // Abort in the middle of a long search
    start = 1'b1;
    value = W'(6765);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(ready), 0);
    chk("abort_index", int'(index), 0);
    chk("abort_is_fib", int'(is_fib), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_no_ready", int'(ready), 0);

    run_one(8, 1'b1);
    run_one(6765, 1'b1);
    for (int i = 0; i < 60; i++)
      run_one(rand_val(), 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
